mmio_target_responder: RTL and testbench

- Bus target (responder) side of the memory-mapped I/O scheme whose initiator-side address decoder drives per-region active-low selects.
- Sits behind one decoded region (default: UART1 window 0x4802_2000–0x4802_2FFF).
- Accepts read/write requests qualified by its select, inserts programmable wait states, and answers with ready/err over a four-phase handshake.
- Backs accesses with a small 32-bit register bank.

---
 rtl/mmio_target_responder_if.sv | 31 +++
 rtl/mmio_target_responder.sv | 165 ++++++++++++++++
 tb/tb_mmio_target_responder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_target_responder_if.sv
// Bus bundle between an initiator and one decoded-region target.
//
// Handshake (four-phase, level request / pulse response):
//   The initiator raises req with cs_n low and holds we/address/wdata
//   steady until the target accepts the request on a rising clock edge.
//   After the programmed wait states, the target pulses ready for exactly
//   one cycle. rdata and err are valid only in that cycle. The initiator
//   keeps req high until it has seen ready, then lowers it. busy stays high
//   from acceptance until the target has observed req low. A new request
//   is accepted no earlier than one cycle after req falls.
interface mmio_target_responder_if;
  logic        cs_n;
  logic        req;
  logic        we;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output cs_n, req, we, address, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  cs_n, req, we, address, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mmio_target_responder.sv
// Target side of one decoded MMIO region. It accepts a request qualified by
// the active-low select and latches the command. After WAIT_STATES idle
// cycles it answers with a one-cycle ready strobe carrying rdata/err.
// Register 0 is a read-only ID. Registers 1..NUM_REGS-1 are read/write.
module mmio_target_responder #(
  parameter logic [31:0] BASE        = 32'h4802_2000,
  parameter int          WIN_BYTES   = 4096,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h5541_5254
) (
  input  logic                    clk,
  input  logic                    RESET,
  mmio_target_responder_if.slave  bus,
  output logic [1:0]              dbg_state
);

  localparam int          IDXW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] WIN_L  = 32'(WIN_BYTES);
  localparam logic [31:0] NREG_L = 32'(NUM_REGS);
  localparam logic [3:0]  WS_L   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_r;
  logic        ready_r;
  logic        err_r;
  logic        busy_r;

  logic [31:0] regs [NUM_REGS];

  // Decode source: the live bus while idle (needed when there are no wait
  // states and the response is formed on the accepting edge), otherwise
  // the latched command so later bus activity cannot disturb it.
  logic [31:0] dec_addr;
  logic        dec_we;
  logic [31:0] dec_offset;
  logic [31:0] dec_word;
  logic [IDXW-1:0] dec_idx;
  logic        dec_out_of_win;
  logic        dec_misaligned;
  logic        dec_unmapped;
  logic        dec_ro_write;
  logic        dec_err;
  logic [31:0] dec_rdata;
  logic        wr_en;

  // Address decode and read-data selection for the pending access.
  always_comb begin
    dec_addr       = (state == ST_IDLE) ? bus.address : addr_q;
    dec_we         = (state == ST_IDLE) ? bus.we      : we_q;
    // Unsigned subtract: addresses below BASE wrap to a huge offset and
    // land out of window instead of aliasing into the register bank.
    dec_offset     = dec_addr - BASE;
    dec_word       = dec_offset >> 2;
    dec_idx        = dec_word[IDXW-1:0];
    dec_out_of_win = (dec_offset >= WIN_L);
    dec_misaligned = (dec_addr[1:0] != 2'b00);
    dec_unmapped   = (dec_word >= NREG_L);
    dec_ro_write   = dec_we && (dec_word == 32'd0);
    dec_err        = dec_out_of_win || dec_misaligned || dec_unmapped || dec_ro_write;
    dec_rdata      = 32'd0;
    if (!dec_err && !dec_we) begin
      dec_rdata = (dec_idx == '0) ? ID_VALUE : regs[dec_idx];
    end
  end

  // A write commits at the end of the single response cycle, and only when
  // the decode was clean.
  assign wr_en = (state == ST_RESP) && we_q && !dec_err;

  // Register bank storage. Entry 0 is shadowed by ID_VALUE on reads and is
  // never written because a write to offset 0 decodes as an error.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wr_en) begin
      regs[dec_idx] <= wdata_q;
    end
  end

  // Transaction FSM with registered ready/err/rdata/busy.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_r  <= 32'd0;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      // Response fields are strobes: they are held only in the RESP cycle.
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (bus.req && !bus.cs_n) begin
            we_q     <= bus.we;
            addr_q   <= bus.address;
            wdata_q  <= bus.wdata;
            busy_r   <= 1'b1;
            wait_cnt <= WS_L;
            if (WS_L == 4'd0) begin
              state   <= ST_RESP;
              ready_r <= 1'b1;
              err_r   <= dec_err;
              rdata_r <= dec_rdata;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= 4'd0;
            state    <= ST_RESP;
            ready_r  <= 1'b1;
            err_r    <= dec_err;
            rdata_r  <= dec_rdata;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_DONE;
        end
        ST_DONE: begin
          // Stay here while the initiator still holds req, so one request
          // produces exactly one ready pulse.
          if (!bus.req) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;
  assign bus.err   = err_r;
  assign bus.busy  = busy_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_mmio_target_responder.sv
// Bench for mmio_target_responder: a 2-wait-state instance (sel=0) and a
// zero-wait-state instance (sel=1) share clock and reset. A behavioural
// register-bank model predicts every response.
module tb_mmio_target_responder;

  localparam logic [31:0] BASE = 32'h4802_2000;
  localparam logic [31:0] ID   = 32'h5541_5254;

  logic clk = 1'b0;
  logic RESET;
  logic [1:0] dbg2;
  logic [1:0] dbg0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_regs [2][16];
  logic [31:0] exp_q [$];

  mmio_target_responder_if bus2 ();
  mmio_target_responder_if bus0 ();

  mmio_target_responder #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .RESET(RESET), .bus(bus2), .dbg_state(dbg2)
  );

  mmio_target_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .RESET(RESET), .bus(bus0), .dbg_state(dbg0)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel, input logic c, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      bus0.cs_n = c; bus0.req = r; bus0.we = w; bus0.address = a; bus0.wdata = d;
    end else begin
      bus2.cs_n = c; bus2.req = r; bus2.we = w; bus2.address = a; bus2.wdata = d;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? bus0.ready : bus2.ready;
  endfunction
  function automatic logic get_err(input bit sel);
    return sel ? bus0.err : bus2.err;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? bus0.busy : bus2.busy;
  endfunction
  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? bus0.rdata : bus2.rdata;
  endfunction

  // Runs one full four-phase transaction starting at a falling edge.
  // lat counts cycles from the accepting edge to the ready cycle (-1 on
  // timeout). busy_ok is cleared if busy is ever low while the transaction
  // is outstanding. idle_ok is cleared if rdata/err linger after the
  // response or busy never falls. pulses counts ready strobes.
  task automatic run_txn(input bit sel, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int hold,
                         input bit scramble, input bit drop_cs,
                         output logic [31:0] got_rd, output logic got_err,
                         output int lat, output bit busy_ok,
                         output int pulses, output bit idle_ok);
    bit fell;
    got_rd = 32'd0; got_err = 1'b0; lat = -1; busy_ok = 1'b1;
    pulses = 0; idle_ok = 1'b1; fell = 1'b0;
    drive(sel, 1'b0, 1'b1, w, a, d);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (get_ready(sel)) begin
        lat = n; got_rd = get_rdata(sel); got_err = get_err(sel); pulses = 1;
      end else begin
        if (!get_busy(sel)) busy_ok = 1'b0;
        // The command is already latched; disturbing the bus must not matter.
        if (scramble)
          drive(sel, drop_cs, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        else if (drop_cs)
          drive(sel, 1'b1, 1'b1, w, a, d);
      end
    end
    if (lat > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (get_ready(sel)) pulses++;
        if (!get_busy(sel)) busy_ok = 1'b0;
        if (get_rdata(sel) !== 32'd0 || get_err(sel) !== 1'b0) idle_ok = 1'b0;
      end
    end
    drive(sel, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int n = 0; n < 4 && !fell; n++) begin
      @(negedge clk);
      if (get_ready(sel)) pulses++;
      if (get_rdata(sel) !== 32'd0 || get_err(sel) !== 1'b0) idle_ok = 1'b0;
      if (!get_busy(sel)) fell = 1'b1;
    end
    if (!fell) idle_ok = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Register bank as an array, decode from the address arithmetic rules.
  function automatic void model_access(input bit sel, input bit w,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic e, output logic [31:0] r);
    logic [31:0] off;
    int unsigned word;
    off  = a - BASE;
    word = off / 4;
    e = (off >= 32'd4096) || (a % 4 != 0) || (word >= 16) || (w && word == 0);
    r = 32'd0;
    if (!e) begin
      if (w) model_regs[sel][word] = d;
      else   r = (word == 0) ? ID : model_regs[sel][word];
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        model_regs[s][i] = 32'd0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({get_ready(s[0]), get_err(s[0]), get_busy(s[0])} !== 3'b000) begin
        failures++;
        $display("FAIL reset_flags[%0d]: ready/err/busy got %b want 000", s,
                 {get_ready(s[0]), get_err(s[0]), get_busy(s[0])});
      end
      checks++;
      if (get_rdata(s[0]) !== 32'd0) begin
        failures++;
        $display("FAIL reset_rdata[%0d]: got %h want 00000000", s, get_rdata(s[0]));
      end
    end
    RESET = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_id();
    logic [31:0] rd; logic e; int lat; bit bok; int p; bit iok;
    run_txn(1'b0, 1'b0, BASE, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (lat !== 3) begin failures++; $display("FAIL read_id latency: got %0d want 3", lat); end
    checks++; if (rd !== ID) begin failures++; $display("FAIL read_id rdata: got %h want %h", rd, ID); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL read_id err: got %b want 0", e); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL read_id busy: got low while pending, want high"); end
    checks++; if (iok !== 1'b1 || p !== 1) begin failures++; $display("FAIL read_id finish: pulses %0d idle_ok %b want 1 1", p, iok); end
  endtask

  task automatic test_write_readback();
    logic [31:0] rd; logic e; int lat; bit bok; int p; bit iok;
    run_txn(1'b0, 1'b1, BASE + 32'd4, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (e !== 1'b0 || lat !== 3) begin failures++; $display("FAIL write4: err %b lat %0d want 0 3", e, lat); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL write4 rdata: got %h want 00000000", rd); end
    model_access(1'b0, 1'b1, BASE + 32'd4, 32'hDEAD_BEEF, e, rd);
    run_txn(1'b0, 1'b0, BASE + 32'd4, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin failures++; $display("FAIL readback4: rdata %h err %b want deadbeef 0", rd, e); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat; bit bok; int p; bit iok;
    run_txn(1'b0, 1'b0, BASE + 32'h40, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (e !== 1'b1 || rd !== 32'd0 || p !== 1) begin failures++; $display("FAIL unmapped: err %b rdata %h pulses %0d want 1 0 1", e, rd, p); end
    run_txn(1'b0, 1'b0, BASE + 32'h6, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (e !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL misaligned: err %b rdata %h want 1 0", e, rd); end
    run_txn(1'b0, 1'b1, BASE, 32'h1234, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL write_id: err %b want 1", e); end
    run_txn(1'b0, 1'b0, BASE, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (rd !== ID || e !== 1'b0) begin failures++; $display("FAIL id_after_write: rdata %h err %b want %h 0", rd, e, ID); end
    run_txn(1'b0, 1'b0, BASE - 32'd4, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (e !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL below_base: err %b rdata %h want 1 0", e, rd); end
    run_txn(1'b0, 1'b0, BASE + 32'd4096 + 32'd4, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL above_window: err %b want 1", e); end
  endtask

  task automatic test_select_gating();
    logic [31:0] rd; logic e; int lat; bit bok; int p; bit iok;
    int bad;
    bad = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, BASE, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (get_ready(1'b0) !== 1'b0 || get_busy(1'b0) !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL gating_idle: %0d cycles with ready/busy, want 0", bad); end
    run_txn(1'b0, 1'b0, BASE, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (lat !== 3 || rd !== ID) begin failures++; $display("FAIL gating_select: lat %0d rdata %h want 3 %h", lat, rd, ID); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int lat; bit bok; int p; bit iok;
    logic [31:0] d;
    logic [31:0] mr; logic me;
    d = $urandom;
    model_access(1'b0, 1'b1, BASE + 32'd12, d, me, mr);
    run_txn(1'b0, 1'b1, BASE + 32'd12, d, 6, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (p !== 1) begin failures++; $display("FAIL hold_pulses: got %0d want 1", p); end
    checks++; if (bok !== 1'b1 || iok !== 1'b1) begin failures++; $display("FAIL hold_busy: busy_ok %b idle_ok %b want 1 1", bok, iok); end
    model_access(1'b0, 1'b0, BASE + 32'd12, 32'd0, me, mr);
    run_txn(1'b0, 1'b0, BASE + 32'd12, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (lat !== 3 || rd !== mr) begin failures++; $display("FAIL back_to_back: lat %0d rdata %h want 3 %h", lat, rd, mr); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; bit bok; int p; bit iok;
    logic [31:0] mr; logic me;
    int seen;
    seen = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, BASE + 32'd8, 32'hCAFE_0001);
    @(negedge clk);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (get_ready(1'b0) !== 1'b0) seen++;
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (get_ready(1'b0) !== 1'b0 || get_busy(1'b0) !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_abort: %0d cycles with ready/busy, want 0", seen); end
    model_access(1'b0, 1'b0, BASE + 32'd8, 32'd0, me, mr);
    run_txn(1'b0, 1'b0, BASE + 32'd8, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (rd !== mr || e !== me) begin failures++; $display("FAIL reset_no_commit: rdata %h err %b want %h %b", rd, e, mr, me); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic e; int lat; bit bok; int p; bit iok;
    logic [31:0] d;
    logic [31:0] mr; logic me;
    run_txn(1'b1, 1'b0, BASE, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (lat !== 1 || rd !== ID) begin failures++; $display("FAIL ws0_read_id: lat %0d rdata %h want 1 %h", lat, rd, ID); end
    d = $urandom;
    model_access(1'b1, 1'b1, BASE + 32'd60, d, me, mr);
    run_txn(1'b1, 1'b1, BASE + 32'd60, d, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (lat !== 1 || e !== me) begin failures++; $display("FAIL ws0_write: lat %0d err %b want 1 %b", lat, e, me); end
    model_access(1'b1, 1'b0, BASE + 32'd60, 32'd0, me, mr);
    run_txn(1'b1, 1'b0, BASE + 32'd60, 32'd0, 0, 1'b0, 1'b0, rd, e, lat, bok, p, iok);
    checks++; if (rd !== mr) begin failures++; $display("FAIL ws0_readback: rdata %h want %h", rd, mr); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic e; int lat; bit bok; int p; bit iok;
    logic [31:0] a, d, mr, exp_rd;
    logic me, w;
    bit sel;
    int kind;
    for (int i = 0; i < 80; i++) begin
      sel  = 1'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      d    = $urandom;
      kind = $urandom_range(0, 6);
      case (kind)
        4:       a = BASE + 32'($urandom_range(0, 4095));
        5:       a = BASE - 32'($urandom_range(1, 64));
        6:       a = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 8));
        default: a = BASE + 32'(4 * $urandom_range(0, 17));
      endcase
      model_access(sel, w, a, d, me, mr);
      exp_q.push_back(mr);
      run_txn(sel, w, a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rd, e, lat, bok, p, iok);
      exp_rd = exp_q.pop_front();
      checks++; if (lat !== (sel ? 1 : 3)) begin failures++; $display("FAIL rand[%0d] latency: got %0d want %0d", i, lat, sel ? 1 : 3); end
      checks++; if (e !== me) begin failures++; $display("FAIL rand[%0d] err: addr %h we %b got %b want %b", i, a, w, e, me); end
      checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rand[%0d] rdata: addr %h got %h want %h", i, a, rd, exp_rd); end
      checks++; if (p !== 1 || bok !== 1'b1 || iok !== 1'b1) begin failures++; $display("FAIL rand[%0d] handshake: pulses %0d busy_ok %b idle_ok %b want 1 1 1", i, p, bok, iok); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RESET = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    test_reset();
    test_read_id();
    test_write_readback();
    test_errors();
    test_select_gating();
    test_back_to_back();
    test_zero_wait();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
